// File: rtl/mostra_sequencia_pkg.sv
// Shared definitions for the sequence presenter: state codes, default timings and
// the timer width helper.
package mostra_sequencia_pkg;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        CARREGA = 4'd2,
        ACENDE  = 4'd3,
        APAGA   = 4'd4,
        PROXIMO = 4'd5,
        FIM     = 4'd6
    } estado_t;

    localparam int TEMPO_ON_PADRAO  = 1000;
    localparam int TEMPO_OFF_PADRAO = 500;

    // Timer holds T-1 at most, so clog2 of the longer period is enough (never below 1 bit).
    function automatic int largura_timer(input int tempo_on, input int tempo_off);
        int maior;
        maior = (tempo_on > tempo_off) ? tempo_on : tempo_off;
        return ($clog2(maior) < 1) ? 1 : $clog2(maior);
    endfunction

endpackage

// File: rtl/mostra_sequencia_if.sv
// Sequence ROM port shared with the jogada datapath: address out, 1-cycle registered data back.
interface mostra_sequencia_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] mem_endereco;
    logic [3:0]        mem_dado;

    modport master (output mem_endereco, input mem_dado);
    modport slave  (input mem_endereco, output mem_dado);
endinterface

// File: rtl/mostra_sequencia_temporizador.sv
// temporizador_seq: loadable down-counter with clear; fim is high while the count is zero.
module temporizador_seq #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpar,
    input  logic         carregar,
    input  logic [W-1:0] valor,
    input  logic         contar,
    output logic         fim
);
    logic [W-1:0] conta_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conta_reg <= '0;
        end else if (limpar) begin
            conta_reg <= '0;
        end else if (carregar) begin
            conta_reg <= valor;
        end else if (contar && (conta_reg != '0)) begin
            conta_reg <= conta_reg - W'(1);
        end
    end

    assign fim = (conta_reg == '0);
endmodule

// File: rtl/mostra_sequencia.sv
// Sequence presenter FSM: walks ROM positions 0..limite, lighting each value on the leds.
// Blank gap between values only when MOSTRA_SEQUENCIA_GAP_EN is defined.
module mostra_sequencia
    import mostra_sequencia_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int TEMPO_ON  = TEMPO_ON_PADRAO,
    parameter int TEMPO_OFF = TEMPO_OFF_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] limite,
    mostra_sequencia_if.master mem,
    output logic [3:0]        leds,
    output logic              mostrando,
    output logic              pronto,
    output logic [3:0]        db_estado
);
    localparam int TW = largura_timer(TEMPO_ON, TEMPO_OFF);
    localparam logic [TW-1:0] CARGA_ON  = TW'(TEMPO_ON - 1);
    localparam logic [TW-1:0] CARGA_OFF = TW'(TEMPO_OFF - 1);

    estado_t           estado_reg;
    logic [ADDR_W-1:0] endereco_reg;
    logic [3:0]        leds_reg;
    logic              mostrando_reg;
    logic              pronto_reg;

    logic              tempo_fim;
    logic              tempo_limpar;
    logic              tempo_carregar;
    logic              tempo_contar;
    logic [TW-1:0]     tempo_valor;
    logic              ultima;

    // Address saturates at all-ones: reaching it ends the run even if limite is larger.
    assign ultima = (endereco_reg == limite) || (&endereco_reg);

    always_comb begin
        tempo_limpar = !(estado_reg inside {CARREGA, ACENDE, APAGA});
        tempo_contar = (estado_reg inside {ACENDE, APAGA});
        tempo_valor  = (estado_reg == ACENDE) ? CARGA_OFF : CARGA_ON;
`ifdef MOSTRA_SEQUENCIA_GAP_EN
        tempo_carregar = (estado_reg == CARREGA) || ((estado_reg == ACENDE) && tempo_fim);
`else
        tempo_carregar = (estado_reg == CARREGA);
`endif
    end

    temporizador_seq #(.W(TW)) u_temporizador (
        .clock    (clock),
        .reset    (reset),
        .limpar   (tempo_limpar),
        .carregar (tempo_carregar),
        .valor    (tempo_valor),
        .contar   (tempo_contar),
        .fim      (tempo_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_reg    <= INICIAL;
            endereco_reg  <= '0;
            leds_reg      <= '0;
            mostrando_reg <= 1'b0;
            pronto_reg    <= 1'b0;
        end else begin
            case (estado_reg)
                INICIAL, FIM: begin
                    if (iniciar) begin
                        estado_reg    <= PREPARA;
                        endereco_reg  <= '0;
                        mostrando_reg <= 1'b1;
                        pronto_reg    <= 1'b0;
                    end
                end
                PREPARA: estado_reg <= CARREGA;
                CARREGA: begin
                    leds_reg   <= mem.mem_dado;
                    estado_reg <= ACENDE;
                end
                ACENDE: begin
                    if (tempo_fim) begin
                        leds_reg <= '0;
`ifdef MOSTRA_SEQUENCIA_GAP_EN
                        estado_reg <= APAGA;
`else
                        if (ultima) begin
                            estado_reg    <= FIM;
                            pronto_reg    <= 1'b1;
                            mostrando_reg <= 1'b0;
                        end else begin
                            estado_reg   <= PROXIMO;
                            endereco_reg <= endereco_reg + ADDR_W'(1);
                        end
`endif
                    end
                end
                APAGA: begin
                    if (tempo_fim) begin
                        if (ultima) begin
                            estado_reg    <= FIM;
                            pronto_reg    <= 1'b1;
                            mostrando_reg <= 1'b0;
                        end else begin
                            estado_reg   <= PROXIMO;
                            endereco_reg <= endereco_reg + ADDR_W'(1);
                        end
                    end
                end
                PROXIMO: estado_reg <= CARREGA;
                default: estado_reg <= INICIAL;
            endcase
        end
    end

    assign mem.mem_endereco = endereco_reg;
    assign leds             = leds_reg;
    assign mostrando        = mostrando_reg;
    assign pronto           = pronto_reg;
    assign db_estado        = estado_reg;
endmodule
